// File: rtl/io_ring_power_seq.sv
// Purpose: pad-ring power sequencer; settles after IO supply good, then staggers bank output-enables up.
// Latency: supply_ok acts after a 2-flop sync plus one edge; req_en and clr_fault act on the next edge.
// Backpressure: none; req_en is a level request with no handshake. Optional macro: IOSEQ_RAMPDOWN_EN.
module io_ring_power_seq #(
   parameter int NUM_BANKS      = 4,
   parameter int SETTLE_CYCLES  = 256,
   parameter int STAGGER_CYCLES = 16,
   parameter int CNT_W          = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 supply_ok,
   input  logic                 req_en,
   input  logic                 clr_fault,
   output logic [NUM_BANKS-1:0] oe_bank,
   output logic                 ready,
   output logic                 fault
);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_SETTLE,
      ST_STAGGER,
      ST_ON,
      ST_FAULT
`ifdef IOSEQ_RAMPDOWN_EN
      , ST_RAMPDOWN
`endif
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_BANKS-1:0] oe_q;
   logic                 ready_q;
   logic                 fault_q;
   logic                 sync1_q;
   logic                 sok_q;

   logic [CNT_W-1:0]     cnt_inc_d;
   logic [NUM_BANKS-1:0] oe_up_d;

   // Next counter value and next thermometer step upward (one more bank on).
   assign cnt_inc_d = cnt_q + CNT_W'(1);
   assign oe_up_d   = (oe_q << 1) | NUM_BANKS'(1);

`ifdef IOSEQ_RAMPDOWN_EN
   logic [NUM_BANKS-1:0] oe_dn_d;
   // Next thermometer step downward (highest enabled bank off).
   assign oe_dn_d = oe_q >> 1;
`endif

   // Two-flop synchronizer for the asynchronous supply level detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sok_q   <= 1'b0;
      end else begin
         sync1_q <= supply_ok;
         sok_q   <= sync1_q;
      end
   end

   // Sequencer FSM with registered bank enables, ready and sticky fault.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         oe_q    <= '0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               oe_q    <= '0;
               ready_q <= 1'b0;
               cnt_q   <= '0;
               if (sok_q && req_en && !fault_q) begin
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!sok_q || !req_en) begin
                  state_q <= ST_OFF;
                  cnt_q   <= '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  // First bank turns on the same edge the settle period ends.
                  oe_q    <= NUM_BANKS'(1);
                  cnt_q   <= '0;
                  state_q <= (NUM_BANKS == 1) ? ST_ON : ST_STAGGER;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            ST_STAGGER, ST_ON: begin
               if (!sok_q) begin
                  // Supply loss with drivers up beats every other event.
                  state_q <= ST_FAULT;
                  oe_q    <= '0;
                  ready_q <= 1'b0;
                  fault_q <= 1'b1;
                  cnt_q   <= '0;
               end else if (!req_en) begin
                  ready_q <= 1'b0;
                  cnt_q   <= '0;
`ifdef IOSEQ_RAMPDOWN_EN
                  oe_q    <= oe_dn_d;
                  state_q <= (oe_dn_d == '0) ? ST_OFF : ST_RAMPDOWN;
`else
                  oe_q    <= '0;
                  state_q <= ST_OFF;
`endif
               end else if (state_q == ST_ON) begin
                  ready_q <= 1'b1;
               end else if (cnt_q == STAGGER_LAST) begin
                  oe_q  <= oe_up_d;
                  cnt_q <= '0;
                  if (oe_up_d == '1) begin
                     state_q <= ST_ON;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            ST_FAULT: begin
               oe_q    <= '0;
               ready_q <= 1'b0;
               cnt_q   <= '0;
               // Clearing is refused until the supply is back.
               if (clr_fault && sok_q) begin
                  fault_q <= 1'b0;
                  state_q <= ST_OFF;
               end
            end
`ifdef IOSEQ_RAMPDOWN_EN
            ST_RAMPDOWN: begin
               ready_q <= 1'b0;
               if (!sok_q) begin
                  state_q <= ST_FAULT;
                  oe_q    <= '0;
                  fault_q <= 1'b1;
                  cnt_q   <= '0;
               end else if (cnt_q == STAGGER_LAST) begin
                  oe_q  <= oe_dn_d;
                  cnt_q <= '0;
                  if (oe_dn_d == '0) begin
                     state_q <= ST_OFF;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
`endif
            default: begin
               state_q <= ST_OFF;
               oe_q    <= '0;
               ready_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign oe_bank = oe_q;
   assign ready   = ready_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_io_ring_power_seq.sv
// Directed bench for io_ring_power_seq at default parameters.
// Edges are counted from the first edge that samples the raised inputs.
// Inputs change and outputs are sampled 1 ns after a rising edge.
module tb_io_ring_power_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       supply_ok;
   logic       req_en;
   logic       clr_fault;
   logic [3:0] oe_bank;
   logic       ready;
   logic       fault;

   int checks   = 0;
   int failures = 0;

   io_ring_power_seq #(
      .NUM_BANKS     (4),
      .SETTLE_CYCLES (256),
      .STAGGER_CYCLES(16),
      .CNT_W         (9)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .supply_ok(supply_ok),
      .req_en   (req_en),
      .clr_fault(clr_fault),
      .oe_bank  (oe_bank),
      .ready    (ready),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] e_oe, input logic e_rdy,
                             input logic e_flt);
      chk({tag, ".oe"}, 32'(oe_bank), 32'(e_oe));
      chk({tag, ".ready"}, 32'(ready), 32'(e_rdy));
      chk({tag, ".fault"}, 32'(fault), 32'(e_flt));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      supply_ok = 1'b0;
      req_en    = 1'b0;
      clr_fault = 1'b0;
      tick(2);
      check_outs("reset", 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      // Power-up: first bank at edge 259, then every 16 edges, ready one edge after 1111.
      do_reset();
      supply_ok = 1'b1;
      req_en    = 1'b1;
      tick(258);
      check_outs("pu_settle_end", 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("pu_bank0", 4'b0001, 1'b0, 1'b0);
      tick(15);
      check_outs("pu_bank0_hold", 4'b0001, 1'b0, 1'b0);
      tick(1);
      check_outs("pu_bank1", 4'b0011, 1'b0, 1'b0);
      tick(16);
      check_outs("pu_bank2", 4'b0111, 1'b0, 1'b0);
      tick(16);
      check_outs("pu_bank3", 4'b1111, 1'b0, 1'b0);
      tick(1);
      check_outs("pu_ready", 4'b1111, 1'b1, 1'b0);

      // clr_fault outside FAULT does nothing.
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      check_outs("clr_in_on", 4'b1111, 1'b1, 1'b0);

      // Supply loss in ON: two sync edges, then tristate and fault on the third.
      supply_ok = 1'b0;
      tick(2);
      check_outs("loss_sync", 4'b1111, 1'b1, 1'b0);
      tick(1);
      check_outs("loss_fault", 4'b0000, 1'b0, 1'b1);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      check_outs("clr_no_supply", 4'b0000, 1'b0, 1'b1);
      supply_ok = 1'b1;
      tick(2);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      check_outs("clr_ok", 4'b0000, 1'b0, 1'b0);
      // Back in OFF: SETTLE next edge, first bank 256 edges after that.
      tick(256);
      check_outs("relaunch_settle", 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("relaunch_bank0", 4'b0001, 1'b0, 1'b0);

      // Early abort: supply_ok low 3 edges at settle count 100 (edge 103).
      do_reset();
      supply_ok = 1'b1;
      req_en    = 1'b1;
      tick(103);
      supply_ok = 1'b0;
      tick(3);
      check_outs("abort_off", 4'b0000, 1'b0, 1'b0);
      supply_ok = 1'b1;
      // sok high again after edge 108, SETTLE at 109, first bank at 365.
      tick(258);
      check_outs("abort_restart", 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("abort_bank0", 4'b0001, 1'b0, 1'b0);

      // Simultaneous drop at 0011: supply_ok leads by the sync depth so the
      // sequencer sees sok and req_en fall on the same edge.
      do_reset();
      supply_ok = 1'b1;
      req_en    = 1'b1;
      tick(275);
      check_outs("simul_pre", 4'b0011, 1'b0, 1'b0);
      supply_ok = 1'b0;
      tick(2);
      check_outs("simul_sync", 4'b0011, 1'b0, 1'b0);
      req_en = 1'b0;
      tick(1);
      check_outs("simul_fault", 4'b0000, 1'b0, 1'b1);

      // Request drop from ON.
      do_reset();
      supply_ok = 1'b1;
      req_en    = 1'b1;
      tick(307);
      check_outs("rd_on", 4'b1111, 1'b0, 1'b0);
      tick(1);
      check_outs("rd_ready", 4'b1111, 1'b1, 1'b0);
      req_en = 1'b0;
`ifdef IOSEQ_RAMPDOWN_EN
      tick(1);
      check_outs("ramp_c1", 4'b0111, 1'b0, 1'b0);
      tick(15);
      check_outs("ramp_c16", 4'b0111, 1'b0, 1'b0);
      tick(1);
      check_outs("ramp_c17", 4'b0011, 1'b0, 1'b0);
      tick(3);
      req_en = 1'b1;
      tick(13);
      check_outs("ramp_c33", 4'b0001, 1'b0, 1'b0);
      tick(15);
      check_outs("ramp_c48", 4'b0001, 1'b0, 1'b0);
      tick(1);
      check_outs("ramp_c49", 4'b0000, 1'b0, 1'b0);
      // OFF at 49, SETTLE at 50, first bank at 306.
      tick(256);
      check_outs("ramp_resettle", 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("ramp_bank0", 4'b0001, 1'b0, 1'b0);
`else
      tick(1);
      check_outs("drop_off", 4'b0000, 1'b0, 1'b0);
      req_en = 1'b1;
      // OFF at 1, SETTLE at 2, first bank at 258.
      tick(256);
      check_outs("drop_resettle", 4'b0000, 1'b0, 1'b0);
      tick(1);
      check_outs("drop_bank0", 4'b0001, 1'b0, 1'b0);
`endif

      // Reset mid-stagger at 0111 clears outputs before the next clock edge.
      do_reset();
      supply_ok = 1'b1;
      req_en    = 1'b1;
      tick(291);
      check_outs("mid_pre", 4'b0111, 1'b0, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check_outs("rst_async", 4'b0000, 1'b0, 1'b0);
      tick(1);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
